// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and its future receiver twin:
// bit timing defaults, frame shape, state encoding and the parity helper.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_FRAME_BITS   = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // A seed of 0 yields even parity and a seed of 1 yields odd parity.
    function automatic logic parity_bit(input logic [7:0] data, input logic seed);
        return seed ^ (^data);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Per-bit clock counter: counts 0..CLKS_PER_BIT-1 and flags the last clock of
// each bit; a synchronous restart parks it at zero so a new bit starts aligned.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_restart,
    output logic [TW-1:0] o_tick,
    output logic          o_bit_end
);

    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] r_tick;

    // Bit-period counter, wrapping on the last clock of each bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= '0;
        end else if (i_restart) begin
            r_tick <= '0;
        end else if (r_tick == LAST) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + TW'(1);
        end
    end

    assign o_tick    = r_tick;
    assign o_bit_end = !i_restart && (r_tick == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, parity, stop. A one-byte
// holding register lets the next frame follow the stop bit with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int   CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter logic PARITY_MODE  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] PENULT = TW'(CLKS_PER_BIT - 2);

    uart_state_e   r_state, w_state_nxt;
    logic [7:0]    r_hold;
    logic          r_hold_full, w_hold_full_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_parity, w_parity_nxt;
    logic [2:0]    r_bit_idx, w_bit_idx_nxt;
    logic          r_tx, w_tx_nxt;
    logic          r_tx_ready;
    logic          r_busy;
    logic          r_done, w_done_nxt;
    logic          w_accept, w_load, w_restart, w_bit_end;
    logic [TW-1:0] w_tick;

    assign w_accept  = tx_valid & r_tx_ready;
    assign w_restart = (r_state == ST_IDLE);

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .o_tick    (w_tick),
        .o_bit_end (w_bit_end)
    );

    // Next-state, next-line-level and holding-register bookkeeping.
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_parity_nxt    = r_parity;
        w_bit_idx_nxt   = r_bit_idx;
        w_tx_nxt        = r_tx;
        w_done_nxt      = 1'b0;
        w_load          = 1'b0;
        w_hold_full_nxt = r_hold_full;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                w_load   = r_hold_full;
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_idx_nxt = 3'd0;
                    w_tx_nxt      = r_shift[0];
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_PARITY;
                        w_tx_nxt    = r_parity;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = r_shift[1];
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_state_nxt = ST_PARITY;
                end
            end
            ST_STOP: begin
                // Registered pulse lands on the final clock of the stop bit.
                w_done_nxt = (w_tick == PENULT);
                if (w_bit_end) begin
                    if (r_hold_full) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
        if (w_load) begin
            w_state_nxt     = ST_START;
            w_shift_nxt     = r_hold;
            w_parity_nxt    = parity_bit(r_hold, PARITY_MODE);
            w_tx_nxt        = 1'b0;
            w_hold_full_nxt = 1'b0;
        end else if (w_accept) begin
            w_hold_full_nxt = 1'b1;
        end else begin
            w_hold_full_nxt = r_hold_full;
        end
    end

    // State and output registers; reset aborts any frame and drops the held byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_shift     <= 8'h00;
            r_parity    <= 1'b0;
            r_bit_idx   <= 3'd0;
            r_tx        <= 1'b1;
            r_tx_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_shift     <= w_shift_nxt;
            r_parity    <= w_parity_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_tx        <= w_tx_nxt;
            r_tx_ready  <= !w_hold_full_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done_nxt;
            if (w_accept) begin
                r_hold <= tx_data;
            end
        end
    end

    assign tx_ready = r_tx_ready;
    assign tx       = r_tx;
    assign busy     = r_busy;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level timeline model predicts every
// output each cycle, and a behavioural 16x receiver decodes the line.
module tb_uart_tx;

    localparam int C  = 16;
    localparam int FB = 11 * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx0, rdy0, busy0, done0;
    logic       tx1, rdy1, busy1, done1;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, live_from = 0, last_acc = 0, valid_pct = 100;
    int f_acc[$];
    int f_start[$];
    logic [7:0] f_byte[$];
    logic [7:0] want[$];

    bit         cap_on = 1'b0;
    int         cap_base = 0, cap_busy = 0, cap_done_cnt = 0, cap_done_clk = 0;
    logic [21:0] cap0, cap1;
    logic [2:0]  cap_rdy;

    bit          rx_active = 1'b0;
    int          rx_cnt = 0, rx_ptr = 0;
    logic [10:0] rx_bits;

    uart_tx #(.CLKS_PER_BIT(C), .PARITY_MODE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy0), .tx(tx0), .busy(busy0), .tx_done(done0));

    uart_tx #(.CLKS_PER_BIT(C), .PARITY_MODE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy1), .tx(tx1), .busy(busy1), .tx_done(done1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: each accepted byte owns a frame [start, start+FB) on the line.
    function automatic int first_f();
        int f = f_acc.size() - 3;
        return (f < live_from) ? live_from : f;
    endfunction

    function automatic logic m_ready(input int j);
        for (int f = first_f(); f < f_acc.size(); f++)
            if (f_acc[f] <= j && j < f_start[f]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_busy(input int j);
        for (int f = first_f(); f < f_acc.size(); f++)
            if (j >= f_start[f] && j < f_start[f] + FB) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_done(input int j);
        for (int f = first_f(); f < f_acc.size(); f++)
            if (j == f_start[f] + FB - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_tx(input int j, input logic pm);
        for (int f = first_f(); f < f_acc.size(); f++) begin
            if (j >= f_start[f] && j < f_start[f] + FB) begin
                int b;
                logic [7:0] d;
                b = (j - f_start[f]) / C;
                d = f_byte[f];
                if (b == 0) return 1'b0;
                if (b <= 8) return d[b-1];
                if (b == 9) return pm ^ (^d);
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    task automatic capture();
        int rel = cyc - cap_base;
        if (rel >= 1) begin
            if (busy0) cap_busy++;
            if (done0) begin
                cap_done_cnt++;
                cap_done_clk = rel;
            end
            if ((rel - 1) % C == C / 2 && (rel - 1) / C < 22) begin
                cap0[(rel - 1) / C] = tx0;
                cap1[(rel - 1) / C] = tx1;
            end
            if (rel == 1)   cap_rdy[0] = rdy0;
            if (rel == 100) cap_rdy[1] = rdy0;
            if (rel == 177) cap_rdy[2] = rdy0;
        end
    endtask

    task automatic cap_start();
        cap_base = last_acc;
        cap_busy = 0;
        cap_done_cnt = 0;
        cap_done_clk = 0;
        cap0 = '0;
        cap1 = '0;
        cap_rdy = '0;
        cap_on = 1'b1;
    endtask

    // One clock: model the accept at the edge, then drive the next inputs.
    task automatic step();
        bit acc;
        @(posedge clk);
        cyc++;
        acc = !rst && tx_valid && m_ready(cyc - 1);
        if (acc) begin
            int s;
            s = cyc + 1;
            if (f_acc.size() > live_from && f_start[f_start.size()-1] + FB > s)
                s = f_start[f_start.size()-1] + FB;
            f_acc.push_back(cyc);
            f_start.push_back(s);
            f_byte.push_back(tx_data);
            void'(want.pop_front());
            last_acc = cyc;
        end
        #1;
        if (cap_on) capture();
        if (rst) begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
        end else if (tx_valid && !acc) begin
            tx_valid = 1'b1;
        end else if (want.size() > 0 && $urandom_range(99) < valid_pct) begin
            tx_valid = 1'b1;
            tx_data  = want[0];
        end else begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
        end
    endtask

    task automatic wait_accept();
        int n0 = f_acc.size();
        for (int i = 0; i < 400 && f_acc.size() == n0; i++) step();
        check("accept_timeout", f_acc.size() > n0, 1);
    endtask

    // Per-cycle compare against the model plus a behavioural receiver on dut0.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_tx0", tx0, 1);
            check("rst_rdy0", rdy0, 1);
            check("rst_busy0", busy0, 0);
            check("rst_done0", done0, 0);
            check("rst_tx1", tx1, 1);
            rx_active = 1'b0;
            rx_ptr = live_from;
        end else begin
            check("tx0", tx0, m_tx(cyc, 1'b0));
            check("tx1", tx1, m_tx(cyc, 1'b1));
            check("ready0", rdy0, m_ready(cyc));
            check("ready1", rdy1, m_ready(cyc));
            check("busy0", busy0, m_busy(cyc));
            check("busy1", busy1, m_busy(cyc));
            check("done0", done0, m_done(cyc));
            check("done1", done1, m_done(cyc));
            if (rx_active) begin
                if (rx_cnt % C == C / 2) rx_bits[rx_cnt / C] = tx0;
                if (rx_cnt == 10 * C + C / 2) begin
                    check("rx_dataerror", ^rx_bits[9:1], 0);
                    check("rx_frameerror", !rx_bits[10] || rx_bits[0], 0);
                    if (rx_ptr < f_byte.size())
                        check("rx_data", rx_bits[8:1], f_byte[rx_ptr]);
                    else
                        check("rx_extra", rx_ptr, f_byte.size());
                    rx_ptr++;
                    rx_active = 1'b0;
                end
                rx_cnt++;
            end else if (tx0 == 1'b0) begin
                rx_active = 1'b1;
                rx_cnt = 1;
            end
        end
    end

    initial begin
        repeat (3) step();
        check("reset_tx", tx0, 1);
        check("reset_ready", rdy0, 1);
        check("reset_busy", busy0, 0);
        check("reset_done", done0, 0);
        rst = 1'b0;
        repeat (4) step();

        // 0x55: exact bit pattern, frame length and tx_done placement.
        want.push_back(8'h55);
        wait_accept();
        cap_start();
        repeat (199) step();
        cap_on = 1'b0;
        check("frame_55", cap0[10:0], 11'b10010101010);
        check("busy_len_55", cap_busy, 176);
        check("done_clk_55", cap_done_clk, 176);
        check("done_cnt_55", cap_done_cnt, 1);
        check("parity_55_odd", cap1[9], 1);

        // 0x01: parity bit under both seeds.
        want.push_back(8'h01);
        wait_accept();
        cap_start();
        repeat (199) step();
        cap_on = 1'b0;
        check("parity_01_even", cap0[9], 1);
        check("parity_01_odd", cap1[9], 0);

        // Back-to-back 0xA5, 0x3C with no idle gap.
        want.push_back(8'hA5);
        want.push_back(8'h3C);
        wait_accept();
        cap_start();
        repeat (359) step();
        cap_on = 1'b0;
        check("b2b_frames", cap0, {1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0});
        check("b2b_busy", cap_busy, 352);
        check("b2b_done_cnt", cap_done_cnt, 2);
        check("b2b_done_clk", cap_done_clk, 352);
        check("b2b_ready", cap_rdy, 3'b101);

        // Third byte stalls until the held byte moves into the shifter.
        want.push_back(8'h11);
        want.push_back(8'h22);
        want.push_back(8'h33);
        wait_accept();
        cap_start();
        repeat (3 * FB + 30) step();
        cap_on = 1'b0;
        check("third_accept", last_acc - cap_base, 178);
        check("three_busy", cap_busy, 3 * FB);
        check("three_done_cnt", cap_done_cnt, 3);

        // Reset at clock 60 of a frame, then a clean 0xC3.
        want.push_back(8'h5A);
        wait_accept();
        cap_base = last_acc;
        repeat (60) step();
        check("pre_reset_tx", tx0, 0);
        #1;
        rst = 1'b1;
        live_from = f_acc.size();
        #1;
        check("abort_tx", tx0, 1);
        check("abort_ready", rdy0, 1);
        check("abort_busy", busy0, 0);
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();
        want.push_back(8'hC3);
        wait_accept();
        cap_start();
        repeat (199) step();
        cap_on = 1'b0;
        check("frame_c3", cap0[10:0], {1'b1, 1'b0, 8'hC3, 1'b0});

        // Random traffic with random valid gaps through the receiver.
        valid_pct = 50;
        for (int i = 0; i < 256; i++) want.push_back(8'($urandom));
        for (int i = 0; i < 70000 && want.size() > 0; i++) step();
        check("random_drain", want.size(), 0);
        repeat (2 * FB + 20) step();
        check("rx_count", rx_ptr, f_acc.size());

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter matching the team's 16x-oversampled receiver.
- Frame format: start bit, 8 data bits LSB first, parity bit, stop bit. Each bit lasts CLKS_PER_BIT clocks; one frame is 11*CLKS_PER_BIT clocks (176 at default).
- Accepts bytes on a valid/ready handshake into a one-byte holding register, so frames can go out back-to-back with no idle gap.
- Sits between the user logic and the board UART TX pin; drives the line that a peer receiver samples.

Parameters:
- CLKS_PER_BIT, 16, clocks per serial bit (>=2); the receiver's sampling requires 16.
- PARITY_MODE, 1'b0, parity seed: parity bit = PARITY_MODE ^ (XOR of data[7:0]). 0 gives even parity, 1 gives odd parity.

Ports:
- clk  in  1  bit-rate x16 clock, same clock as the receiver.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  holding register empty; a byte is accepted when tx_valid & tx_ready at a rising edge.
- tx  out  1  serial line, idle high.
- busy  out  1  frame in progress (state != IDLE).
- tx_done  out  1  one-cycle pulse in the last clock of the stop bit.

Behaviour:
- Reset values (asynchronous): tx=1, tx_ready=1, busy=0, tx_done=0, state=IDLE, all counters 0, holding register empty. Reset mid-frame aborts the frame: tx goes high immediately and both the in-flight byte and the held byte are discarded.
- Holding register:
  - Written on any edge where tx_valid & tx_ready.
  - tx_ready = !hold_full, registered.
  - hold_full clears on the same edge the byte transfers to the shift register.
  - Accept and transfer on the same edge is impossible, because accept requires hold_full=0.
- States: IDLE, START, DATA, PARITY, STOP.
- tick counter:
  - Counts 0..CLKS_PER_BIT-1 within each bit.
  - A bit ends when tick == CLKS_PER_BIT-1; tick then wraps to 0.
- bit index: 0..7, used only in DATA.
- IDLE:
  - tx=1.
  - If hold_full: load shift register and parity accumulator (PARITY_MODE ^ XOR of data), clear hold_full, go to START.
  - Latency: byte accepted at edge N, held byte loaded at edge N+1, tx low from edge N+1.
- START: tx=0 for CLKS_PER_BIT clocks, then DATA with bit index 0.
- DATA:
  - tx=shift[0] for one bit time.
  - At the end of each bit, shift right; after bit index 7, go to PARITY.
- PARITY: tx=parity bit for one bit time, then STOP.
- STOP:
  - tx=1 for one bit time.
  - On the last clock, pulse tx_done=1.
  - If hold_full, load the next byte and go straight to START (zero idle clocks between frames); otherwise go to IDLE.
- tx is a registered output (no glitches); it changes only on bit boundaries.
- tx_data changing while not accepted has no effect. tx_valid held while tx_ready=0 is a stall; the source must hold tx_data.
- A byte accepted during any state is sent next. At most one byte is pending beyond the one in flight.

Decomposition:
- No shared package required.
- Optional shared package uart_pkg: CLKS_PER_BIT default, frame bit count (11), state encoding localparams, so rx and tx agree.
- One natural sub-module: uart_baud_tick (tick counter with a bit_end strobe and synchronous restart), reusable by a future parameterised receiver. Otherwise implement flat.

Test Plan:
- Reset, then send 0x55 with PARITY_MODE=0:
  - Sampling at tick 8 of each bit gives 0, 1,0,1,0,1,0,1,0, parity 0, stop 1.
  - Frame is 176 clocks long; tx_done pulses at clock 176; busy is high for exactly 176 clocks.
- Send 0x01:
  - PARITY_MODE=0 gives parity bit 1.
  - PARITY_MODE=1 gives parity bit 0.
- Back-to-back 0xA5 then 0x3C (second byte offered while the first is in flight):
  - tx_ready drops after the second accept and re-asserts when the byte loads at the STOP→START edge.
  - The second start bit begins immediately after the first stop bit; total 352 clocks with no idle gap.
- Offer a third byte while busy and the holding register is full:
  - tx_ready=0 and the byte is not accepted until the first frame finishes.
  - All three bytes are sent in order.
- Assert rst at clock 60 of a frame:
  - tx=1 within the same cycle (asynchronous); tx_ready=1; busy=0.
  - After release, a new byte 0xC3 is sent correctly with no remnant of the aborted frame.
- Loopback tx into the team's receiver with random 256 bytes:
  - Every dataout equals the sent byte.
  - dataerror=0 and frameerror=0 throughout.
